// File: rtl/mem_initiator.sv
// mem_initiator: valid/ready initiator for a 32x8 synchronous memory; define MEM_READBACK_EN to verify every write by reading it back.
module mem_initiator #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rd,
  output logic          mem_wr
);
`ifdef MEM_READBACK_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, VREAD, VWAIT} state_t;
  logic err_q;
  assign err = err_q;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_t;
  assign err = 1'b0;
`endif
  state_t        state_q;
  logic          mem_rd_q, mem_wr_q, rsp_valid_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, rsp_rdata_q;
  assign req_ready = (state_q == IDLE) && !rst;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  // mem_addr_q/mem_wdata_q double as the captured request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MEM_READBACK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef MEM_READBACK_EN
      err_q       <= 1'b0;
`endif
      case (state_q)
        IDLE: if (req_valid) begin
          mem_addr_q  <= req_addr;
          mem_wdata_q <= req_wdata;
          mem_wr_q    <= req_we;
          mem_rd_q    <= !req_we;
          state_q     <= req_we ? WRITE : READ;
        end
        WRITE: begin
          mem_wr_q <= 1'b0;
`ifdef MEM_READBACK_EN
          mem_rd_q <= 1'b1;
          state_q  <= VREAD;
`else
          rsp_valid_q <= 1'b1;
          state_q     <= IDLE;
`endif
        end
        READ: begin
          mem_rd_q <= 1'b0;
          state_q  <= RWAIT;
        end
        RWAIT: begin
          rsp_rdata_q <= mem_rdata;
          rsp_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
`ifdef MEM_READBACK_EN
        VREAD: begin
          mem_rd_q <= 1'b0;
          state_q  <= VWAIT;
        end
        VWAIT: begin
          rsp_rdata_q <= mem_rdata;
          err_q       <= mem_rdata != mem_wdata_q;
          rsp_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: directed bench with a transaction-timeline model of mem_initiator and a behavioural 32x8 memory.
module tb_mem_initiator;
  logic       clk = 1'b0, rst = 1'b1, init = 1'b1;
  logic       req_valid = 1'b0, req_we = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, err, mem_rd, mem_wr;
  logic [7:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [4:0] mem_addr;
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  mem_initiator dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr)
  );
  function automatic logic [7:0] pre(input int i);
    return i == 31 ? 8'h11 : i == 0 ? 8'h22 : i == 7 ? 8'h77 : 8'(i * 3 + 1);
  endfunction
  // the memory under the readback build corrupts whatever it returns from 0x10
  function automatic logic [7:0] rbval(input logic [4:0] a, input logic [7:0] d);
`ifdef MEM_READBACK_EN
    return a == 5'h10 ? ~d : d;
`else
    return a == 5'h1F ? d : d;
`endif
  endfunction
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (init) for (int i = 0; i < 32; i++) mem[i] <= pre(i);
    else begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= rbval(mem_addr, mem[mem_addr]);
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", n, a, e, cyc);
    end
  endtask
  logic [7:0] mdl [32];
  int rd_t = -10, wr_t = -10, rsp_t = -10, cm_t = -10, rdy_t = 0;
  logic [4:0] e_addr = '0, cm_a = '0;
  logic [7:0] e_wdata = '0, e_rdata = '0, p_rdata = '0, cm_d = '0;
  logic p_err = 1'b0;
  int rd_log[$], wr_log[$], rsp_log[$];
  logic [7:0] dat_log[$];
  logic err_log[$];
  always begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      if (init) for (int i = 0; i < 32; i++) mdl[i] = pre(i);
      rd_t = -10; wr_t = -10; rsp_t = -10; cm_t = -10; rdy_t = cyc;
      e_addr = '0; e_wdata = '0; e_rdata = '0; p_err = 1'b0;
    end else begin
      if (cm_t == cyc) mdl[cm_a] = cm_d;
      if (cyc - 1 >= rdy_t && req_valid) begin
        e_addr = req_addr;
        if (req_we) begin
          wr_t = cyc; e_wdata = req_wdata; cm_t = cyc + 1; cm_a = req_addr; cm_d = req_wdata;
`ifdef MEM_READBACK_EN
          rd_t = cyc + 1; rsp_t = cyc + 3; rdy_t = cyc + 3;
          p_rdata = rbval(req_addr, req_wdata); p_err = p_rdata != req_wdata;
`else
          rsp_t = cyc + 1; rdy_t = cyc + 1; p_rdata = e_rdata; p_err = 1'b0;
`endif
        end else begin
          rd_t = cyc; rsp_t = cyc + 2; rdy_t = cyc + 2;
          p_rdata = rbval(req_addr, mdl[req_addr]); p_err = 1'b0;
        end
      end
      if (cyc == rsp_t) e_rdata = p_rdata;
    end
    #1;
    chk("req_ready", req_ready, !rst && cyc >= rdy_t);
    chk("mem_rd", mem_rd, cyc == rd_t);
    chk("mem_wr", mem_wr, cyc == wr_t);
    chk("rd_wr_overlap", mem_rd && mem_wr, 0);
    chk("rsp_valid", rsp_valid, cyc == rsp_t);
    chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("err", err, cyc == rsp_t && p_err);
    chk("mem_addr", mem_addr, e_addr);
    if (cyc == wr_t || rst) chk("mem_wdata", mem_wdata, e_wdata);
    if (mem_rd) rd_log.push_back(cyc);
    if (mem_wr) wr_log.push_back(cyc);
    if (rsp_valid) begin
      rsp_log.push_back(cyc); dat_log.push_back(rsp_rdata); err_log.push_back(err);
    end
  end
  task automatic issue(input logic we, input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_timeout", n < 20, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 5'($urandom); req_wdata = 8'($urandom);
  endtask
  task automatic busy_junk(input int cnt, input logic [4:0] a, input logic [7:0] d, input logic we);
    for (int i = 0; i < cnt; i++) begin
      req_valid = 1'b1; req_we = 1'($urandom); req_addr = 5'($urandom); req_wdata = 8'($urandom);
      @(negedge clk);
      chk("hold_addr", mem_addr, a);
      if (we) chk("hold_wdata", mem_wdata, d);
    end
    req_valid = 1'b0;
  endtask
  task automatic wait_rd(input logic [4:0] a);
    int n = 0;
    while (!(mem_rd === 1'b1 && mem_addr == a) && n < 20) begin @(negedge clk); n++; end
    chk("rd_timeout", n < 20, 1);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    init = 1'b0; rst = 1'b0;
    #1 chk("ready_after_reset", req_ready, 1);
    issue(1'b1, 5'h03, 8'hA5);
    chk("wr_pulse", mem_wr, 1);
    chk("wr_addr", mem_addr, 5'h03);
    chk("wr_data", mem_wdata, 8'hA5);
    busy_junk(1, 5'h03, 8'hA5, 1'b1);
    repeat (4) @(negedge clk);
`ifdef MEM_READBACK_EN
    chk("wr_latency", rsp_log[$] - wr_log[$], 3);
`else
    chk("wr_latency", rsp_log[$] - wr_log[$], 1);
`endif
    chk("wr_err", err_log[$], 0);
    issue(1'b0, 5'h03, 8'h00);
    busy_junk(2, 5'h03, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rd_latency", rsp_log[$] - rd_log[$], 2);
    chk("rd_data", dat_log[$], 8'hA5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rsp_rdata", rsp_rdata, 0);
    chk("async_mem_addr", mem_addr, 0);
    chk("async_mem_wdata", mem_wdata, 0);
    chk("async_ready", req_ready, 0);
    chk("async_rd_wr", {mem_rd, mem_wr, rsp_valid, err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("release_ready", req_ready, 1);
    chk("release_rd_wr", {mem_rd, mem_wr}, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h1F;
    wait_rd(5'h1F);
    req_addr = 5'h00;
    wait_rd(5'h00);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_spacing", rd_log[$] - rd_log[$-1], 3);
    chk("b2b_first", dat_log[$-1], 8'h11);
    chk("b2b_second", dat_log[$], 8'h22);
    issue(1'b0, 5'h07, 8'h00);
    @(negedge clk);
    n = rsp_log.size();
    rst = 1'b1;
    #1 chk("rwait_rst_rsp", rsp_valid, 0);
    chk("rwait_rst_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rwait_no_rsp", rsp_log.size(), n);
    issue(1'b0, 5'h07, 8'h00);
    repeat (3) @(negedge clk);
    chk("rwait_retry_data", dat_log[$], 8'h77);
    chk("rwait_retry_count", rsp_log.size(), n + 1);
`ifdef MEM_READBACK_EN
    issue(1'b1, 5'h10, 8'h5A);
    repeat (5) @(negedge clk);
    chk("rb_latency", rsp_log[$] - wr_log[$], 3);
    chk("rb_err", err_log[$], 1);
    chk("rb_data", dat_log[$], 8'hA5);
    issue(1'b1, 5'h11, 8'h3C);
    repeat (5) @(negedge clk);
    chk("rb_clean_err", err_log[$], 0);
    chk("rb_clean_data", dat_log[$], 8'h3C);
`endif
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = 5'($urandom); req_wdata = 8'($urandom);
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
